// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one 1-bit full-adder slice iterated LSB first over W bits.
// Latency: START sampled at edge k -> DONE pulse in the cycle after edge k+W (F/CO valid then).
// Backpressure: START is honoured only in IDLE/DONE; while BUSY it is ignored, no queuing.
// Optional feature macro: SERIAL_SUB_EN adds sub_i (A-B via ~B and carry-in forced to 1).
module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
`ifdef SERIAL_SUB_EN
  input  logic         sub_i,
`endif
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] f_o,
  output logic         co_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    f_q, f_d;
  logic            c_q, c_d;
  logic            co_q, co_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Subtract select seen by the capture logic; tied low in the add-only build.
  logic            sub_sel;
`ifdef SERIAL_SUB_EN
  assign sub_sel = sub_i;
`else
  assign sub_sel = 1'b0;
`endif

  // The single full-adder slice, always looking at the current LSBs and carry.
  logic slice_a, slice_b, slice_s, slice_co;
  assign slice_a  = a_q[0];
  assign slice_b  = b_q[0];
  assign slice_s  = slice_a ^ slice_b ^ c_q;
  assign slice_co = (slice_a & slice_b) | ((slice_a ^ slice_b) & c_q);

  // Next-state and datapath updates; everything holds unless a branch says otherwise.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    c_d     = c_q;
    co_d    = co_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          // Capture is identical from IDLE and DONE so back-to-back ops lose no cycle.
          // F/CO are left alone here: they keep the previous result until shifting starts.
          state_d = ST_RUN;
          a_d     = a_i;
          b_d     = sub_sel ? ~b_i : b_i;
          c_d     = sub_sel ? 1'b1 : ci_i;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        f_d = {slice_s, f_q[W-1:1]};
        c_d = slice_co;
        if (cnt_q == LAST_BIT) begin
          // MSB slice: its carry is the final carry-out. Counter is not advanced
          // past W-1 so it never wraps for non-power-of-two widths.
          state_d = ST_DONE;
          co_d    = slice_co;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset discards any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      c_q     <= c_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);
  assign f_o    = f_q;
  assign co_o   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vectors plus random ops
// against an arithmetic reference ({CO,F} = A + B + CI, or A - B for subtract).
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk_i;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         ci_i;
  logic         sub_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] f_o;
  logic         co_o;

  int n_cmp;
  int n_err;

  serial_add_ctrl #(.W(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .ci_i    (ci_i),
`ifdef SERIAL_SUB_EN
    .sub_i   (sub_i),
`endif
    .busy_o  (busy_o),
    .done_o  (done_o),
    .f_o     (f_o),
    .co_o    (co_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as the requester sees them.
  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic ci, input logic sub);
    logic [W:0] sum;
    if (sub)
      sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else
      sum = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    return sum;
  endfunction

  // Present an operation at the current negedge and let edge k sample it.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sub, input bit wait_first);
    if (wait_first) @(negedge clk_i);
    a_i     = a;
    b_i     = b;
    ci_i    = ci;
    sub_i   = sub;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Called in the first cycle after edge k. Scrambles inputs (including START)
  // while running, waits for DONE with a bound, then checks latency, BUSY
  // length and result. Returns at the DONE-cycle negedge with START low.
  task automatic finish_op(input string tag, input logic [W:0] exp);
    int cyc;
    int busy_cnt;
    bit seen;
    cyc      = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    while (cyc <= W + 4) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) busy_cnt++;
      a_i     = W'($urandom);
      b_i     = W'($urandom);
      ci_i    = 1'($urandom);
      sub_i   = 1'($urandom);
      start_i = 1'($urandom);
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(W + 1));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, " f"}, 32'(f_o), 32'(exp[W-1:0]));
    check({tag, " co"}, 32'(co_o), 32'(exp[W]));
  endtask

  // Non-chained op: DONE must drop after one cycle and the block go idle with F/CO held.
  task automatic single_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sub);
    logic [W:0] exp;
    exp = ref_result(a, b, ci, sub);
    launch(a, b, ci, sub, 1'b1);
    finish_op(tag, exp);
    @(negedge clk_i);
    check({tag, " done_pulse"}, 32'(done_o), 32'd0);
    check({tag, " idle_busy"}, 32'(busy_o), 32'd0);
    check({tag, " hold_f"}, 32'(f_o), 32'(exp[W-1:0]));
  endtask

  logic sub_en;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    ci_i    = 1'b0;
    sub_i   = 1'b0;
`ifdef SERIAL_SUB_EN
    sub_en = 1'b1;
`else
    sub_en = 1'b0;
`endif
    rst_i = 1'b1;
    #12;
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst f", 32'(f_o), 32'd0);
    check("rst co", 32'(co_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed vectors.
    single_op("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 1'b0);
    check("add_3c_5a const_f", 32'(f_o), 32'h96);
    single_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    check("add_ff_01 const_co", 32'(co_o), 32'd1);
    single_op("add_ff_ff_ci", 8'hFF, 8'hFF, 1'b1, 1'b0);
    check("add_ff_ff_ci const_f", 32'(f_o), 32'hFF);

    // START mid-run (scrambled A=F0 etc.) is ignored; START held in DONE chains.
    launch(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    a_i = 8'hF0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("ignore busy", 32'(busy_o), 32'd1);
    // Bench is now in RUN cycle 3; reuse the waiter with an adjusted view.
    begin
      int cyc;
      cyc = 3;
      while (!done_o && cyc <= W + 4) begin
        @(negedge clk_i);
        cyc++;
      end
      check("ignore latency", 32'(cyc), 32'(W + 1));
      check("ignore f", 32'(f_o), 32'h02);
    end
    launch(8'h22, 8'h33, 1'b1, 1'b0, 1'b0);
    check("b2b busy", 32'(busy_o), 32'd1);
    check("b2b done", 32'(done_o), 32'd0);
    finish_op("b2b", ref_result(8'h22, 8'h33, 1'b1, 1'b0));
    @(negedge clk_i);

    // Async reset during the 4th RUN cycle.
    launch(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk_i);
    check("pre_rst busy", 32'(busy_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst f", 32'(f_o), 32'd0);
    check("midrst co", 32'(co_o), 32'd0);
    check("midrst done", 32'(done_o), 32'd0);
    #1 rst_i = 1'b0;
    repeat (W + 2) begin
      @(negedge clk_i);
      check("post_rst no_done", 32'(done_o), 32'd0);
    end
    single_op("after_rst", 8'h7F, 8'h01, 1'b0, 1'b0);

    if (sub_en) begin
      single_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1);
      check("sub_10_01 const_f", 32'(f_o), 32'h0F);
      single_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1);
      check("sub_01_02 const_co", 32'(co_o), 32'd0);
    end

    // Random operations, roughly a third chained back-to-back.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      logic [W:0] exp;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rc  = 1'($urandom);
      rs  = sub_en & 1'($urandom);
      exp = ref_result(ra, rb, rc, rs);
      launch(ra, rb, rc, rs, 1'b1);
      finish_op($sformatf("rnd%0d", i), exp);
      if ($urandom_range(0, 2) == 0) begin
        ra  = W'($urandom);
        rb  = W'($urandom);
        rc  = 1'($urandom);
        rs  = sub_en & 1'($urandom);
        exp = ref_result(ra, rb, rc, rs);
        launch(ra, rb, rc, rs, 1'b0);
        check($sformatf("rnd%0d chain_busy", i), 32'(busy_o), 32'd1);
        finish_op($sformatf("rnd%0d chain", i), exp);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
